// File: rtl/ceespu_execute_pipe.sv
// ceespu execute stage: single-cycle ALU, iterative mul/div, branch resolve,
// store lane formatting and the EX/MEM pipeline register.
module ceespu_execute_pipe #(
    parameter int XLEN = 32,
    parameter int PCW  = 14,
    parameter int REGW = 5
) (
    input  logic              I_clk,
    input  logic              I_rst,
    input  logic              I_valid,
    input  logic              I_flush,
    input  logic [3:0]        I_aluop,
    input  logic [XLEN-1:0]   I_dataA,
    input  logic [XLEN-1:0]   I_dataB,
    input  logic [XLEN-1:0]   I_storeData,
    input  logic [1:0]        I_selCin,
    input  logic              I_we,
    input  logic [REGW-1:0]   I_regD,
    input  logic              I_memE,
    input  logic              I_memWe,
    input  logic [1:0]        I_selMem,
    input  logic              I_isBranch,
    input  logic [2:0]        I_branchop,
    input  logic              I_prediction,
    input  logic [PCW-1:0]    I_PC,
    input  logic [PCW-1:0]    I_branchTarget,
    output logic [XLEN-1:0]   O_memAddress,
    output logic [XLEN-1:0]   O_storeData,
    output logic [XLEN/8-1:0] O_memWe,
    output logic              O_memE,
    output logic              O_misaligned,
    output logic              O_busy,
    output logic              O_branch_taken,
    output logic              O_branch_mispredict,
    output logic [PCW-1:0]    O_branchTarget,
    output logic              O_valid,
    output logic              O_we,
    output logic [REGW-1:0]   O_regD,
    output logic [XLEN-1:0]   O_result,
    output logic [1:0]        O_selMem,
    output logic [PCW-1:0]    O_PC
);

    localparam int NB = XLEN / 8;
    localparam int SW = $clog2(XLEN);
    localparam int LB = $clog2(NB);
    localparam int CW = SW + 1;

    typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_DONE} state_t;

    state_t            state, state_nx;
    logic [CW-1:0]     cnt, cnt_nx;
    logic [2*XLEN-1:0] acc, acc_nx;
    logic [XLEN-1:0]   opa;
    logic              md_hi;
    logic              c_flag;

    logic              is_md, md_start, accept, is_addsub;
    logic [XLEN:0]     mul_sum;
    logic [XLEN:0]     div_sh;
    logic              div_ge;
    logic [XLEN-1:0]   div_df;
    logic [XLEN-1:0]   md_res;

    assign is_md     = (I_aluop[3:2] == 2'b10);
    assign is_addsub = (I_aluop[3:1] == 3'b000);
    assign md_start  = (state == S_IDLE) & I_valid & is_md & ~I_flush;
    assign O_busy    = md_start | (state == S_MUL) | (state == S_DIV);
    assign accept    = I_valid & ~O_busy & ~I_flush;

    // acc holds {hi, lo}: product or {remainder, quotient}
    assign mul_sum = {1'b0, acc[2*XLEN-1:XLEN]}
                   + (acc[0] ? {1'b0, opa} : {(XLEN+1){1'b0}});
    assign div_sh  = acc[2*XLEN-1:XLEN-1];
    assign div_ge  = (div_sh >= {1'b0, opa});
    assign div_df  = div_sh[XLEN-1:0] - opa;
    assign md_res  = md_hi ? acc[2*XLEN-1:XLEN] : acc[XLEN-1:0];

    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        acc_nx   = acc;
        case (state)
            S_IDLE: begin
                if (md_start) begin
                    state_nx = I_aluop[1] ? S_DIV : S_MUL;
                    cnt_nx   = CW'(XLEN);
                    acc_nx   = {{XLEN{1'b0}}, I_aluop[1] ? I_dataA : I_dataB};
                end
            end
            S_MUL: begin
                acc_nx = {mul_sum, acc[XLEN-1:1]};
                cnt_nx = cnt - CW'(1);
                if (cnt == CW'(1)) state_nx = S_DONE;
            end
            S_DIV: begin
                acc_nx = {div_ge ? div_df : div_sh[XLEN-1:0],
                          acc[XLEN-2:0], div_ge};
                cnt_nx = cnt - CW'(1);
                if (cnt == CW'(1)) state_nx = S_DONE;
            end
            default: state_nx = S_IDLE;
        endcase
        if (I_flush) state_nx = S_IDLE;
    end

    always_ff @(posedge I_clk) begin
        if (I_rst) begin
            state <= S_IDLE;
            cnt   <= '0;
            acc   <= '0;
            opa   <= '0;
            md_hi <= 1'b0;
        end else begin
            state <= state_nx;
            cnt   <= cnt_nx;
            acc   <= acc_nx;
            if (md_start) begin
                opa   <= I_aluop[1] ? I_dataB : I_dataA;
                md_hi <= I_aluop[0];
            end
        end
    end

    logic            cin;
    logic [XLEN-1:0] b_eff;
    logic [XLEN:0]   sum;
    logic [SW-1:0]   shamt;
    logic [XLEN-1:0] alu_res;

    assign shamt = I_dataB[SW-1:0];
    assign b_eff = I_aluop[0] ? ~I_dataB : I_dataB;
    assign sum   = {1'b0, I_dataA} + {1'b0, b_eff} + (XLEN+1)'(cin);

    always_comb begin
        unique case (I_selCin)
            2'd0:    cin = 1'b0;
            2'd1:    cin = c_flag;
            2'd2:    cin = ~c_flag;
            default: cin = 1'b1;
        endcase
    end

    always_comb begin
        alu_res = I_dataB;
        case (I_aluop)
            4'd0, 4'd1: alu_res = sum[XLEN-1:0];
            4'd2:  alu_res = I_dataA & I_dataB;
            4'd3:  alu_res = I_dataA | I_dataB;
            4'd4:  alu_res = I_dataA ^ I_dataB;
            4'd5:  alu_res = I_dataA << shamt;
            4'd6:  alu_res = I_dataA >> shamt;
            4'd7:  alu_res = $signed(I_dataA) >>> shamt;
            4'd8, 4'd9, 4'd10, 4'd11: alu_res = md_res;
            4'd12: alu_res = XLEN'(I_dataA < I_dataB);
            4'd13: alu_res = XLEN'($signed(I_dataA) < $signed(I_dataB));
            default: alu_res = I_dataB;
        endcase
    end

    always_ff @(posedge I_clk) begin
        if (I_rst) begin
            O_valid  <= 1'b0;
            O_we     <= 1'b0;
            O_regD   <= '0;
            O_result <= '0;
            O_selMem <= '0;
            O_PC     <= '0;
            c_flag   <= 1'b0;
        end else begin
            O_valid <= accept;
            O_we    <= accept & I_we;
            if (accept) begin
                O_regD   <= I_regD;
                O_result <= alu_res;
                O_selMem <= I_selMem;
                O_PC     <= I_PC;
            end
            if (accept & is_addsub) c_flag <= sum[XLEN];
        end
    end

    logic [NB-1:0] lane_we;
    logic          mis_raw;

    assign O_memAddress = I_dataA + I_dataB;

    always_comb begin
        O_storeData = I_storeData;
        lane_we     = '1;
        mis_raw     = 1'b0;
        unique case (I_selMem)
            2'd1: begin
                O_storeData = {(NB/2){I_storeData[15:0]}};
                lane_we     = NB'(3) << {O_memAddress[LB-1:1], 1'b0};
                mis_raw     = O_memAddress[0];
            end
            2'd2: begin
                O_storeData = {NB{I_storeData[7:0]}};
                lane_we     = NB'(1) << O_memAddress[LB-1:0];
            end
            default: mis_raw = |O_memAddress[LB-1:0];
        endcase
    end

    assign O_misaligned = I_valid & I_memE & mis_raw;
    assign O_memE  = I_memE & I_valid & ~O_busy & ~I_flush & ~O_misaligned;
    assign O_memWe = (O_memE & I_memWe) ? lane_we : '0;

    always_comb begin
        unique case (I_branchop)
            3'd0:    O_branch_taken = (I_dataA == I_dataB);
            3'd1:    O_branch_taken = (I_dataA != I_dataB);
            3'd2:    O_branch_taken = (I_dataA < I_dataB);
            3'd3:    O_branch_taken = (I_dataA >= I_dataB);
            3'd4:    O_branch_taken = ($signed(I_dataA) < $signed(I_dataB));
            3'd5:    O_branch_taken = ($signed(I_dataA) >= $signed(I_dataB));
            3'd6:    O_branch_taken = 1'b1;
            default: O_branch_taken = c_flag;
        endcase
    end

    assign O_branch_mispredict = I_valid & I_isBranch & ~I_flush
                               & (O_branch_taken != I_prediction);
    assign O_branchTarget = I_prediction ? I_PC : I_branchTarget;

endmodule

// File: tb/tb_ceespu_execute_pipe.sv
// Directed bench for ceespu_execute_pipe: results are queued at issue and
// popped when the pipeline register presents them.
module tb_ceespu_execute_pipe;

    logic        I_clk = 1'b0;
    logic        I_rst, I_valid, I_flush;
    logic [3:0]  I_aluop;
    logic [31:0] I_dataA, I_dataB, I_storeData;
    logic [1:0]  I_selCin;
    logic        I_we;
    logic [4:0]  I_regD;
    logic        I_memE, I_memWe;
    logic [1:0]  I_selMem;
    logic        I_isBranch;
    logic [2:0]  I_branchop;
    logic        I_prediction;
    logic [13:0] I_PC, I_branchTarget;

    logic [31:0] O_memAddress, O_storeData;
    logic [3:0]  O_memWe;
    logic        O_memE, O_misaligned, O_busy;
    logic        O_branch_taken, O_branch_mispredict;
    logic [13:0] O_branchTarget;
    logic        O_valid, O_we;
    logic [4:0]  O_regD;
    logic [31:0] O_result;
    logic [1:0]  O_selMem;
    logic [13:0] O_PC;

    int n_checks = 0;
    int n_fail   = 0;
    logic [31:0] sb_q[$];

    always #5 I_clk = ~I_clk;

    ceespu_execute_pipe #(.XLEN(32), .PCW(14), .REGW(5)) dut (
        .I_clk(I_clk), .I_rst(I_rst), .I_valid(I_valid), .I_flush(I_flush),
        .I_aluop(I_aluop), .I_dataA(I_dataA), .I_dataB(I_dataB),
        .I_storeData(I_storeData), .I_selCin(I_selCin), .I_we(I_we),
        .I_regD(I_regD), .I_memE(I_memE), .I_memWe(I_memWe),
        .I_selMem(I_selMem), .I_isBranch(I_isBranch),
        .I_branchop(I_branchop), .I_prediction(I_prediction),
        .I_PC(I_PC), .I_branchTarget(I_branchTarget),
        .O_memAddress(O_memAddress), .O_storeData(O_storeData),
        .O_memWe(O_memWe), .O_memE(O_memE), .O_misaligned(O_misaligned),
        .O_busy(O_busy), .O_branch_taken(O_branch_taken),
        .O_branch_mispredict(O_branch_mispredict),
        .O_branchTarget(O_branchTarget), .O_valid(O_valid), .O_we(O_we),
        .O_regD(O_regD), .O_result(O_result), .O_selMem(O_selMem),
        .O_PC(O_PC)
    );

    task automatic check(input string tag, input logic [63:0] obs,
                         input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic clear_inputs();
        I_valid = 0; I_flush = 0; I_aluop = 0; I_dataA = 0; I_dataB = 0;
        I_storeData = 0; I_selCin = 0; I_we = 0; I_regD = 0; I_memE = 0;
        I_memWe = 0; I_selMem = 0; I_isBranch = 0; I_branchop = 0;
        I_prediction = 0; I_PC = 0; I_branchTarget = 0;
    endtask

    // called just after a rising edge; returns just after the capture edge
    task automatic run_op(input string tag, input logic [3:0] op,
                          input logic [31:0] a, input logic [31:0] b,
                          input logic [1:0] cin, input logic [4:0] rd,
                          input logic [31:0] exp, input int exp_busy);
        int busy_n;
        logic [31:0] want;
        sb_q.push_back(exp);
        I_valid = 1; I_aluop = op; I_dataA = a; I_dataB = b;
        I_selCin = cin; I_we = 1; I_regD = rd; I_PC = {9'd0, rd};
        I_memE = 0; I_isBranch = 0; I_selMem = 0;
        busy_n = 0;
        @(negedge I_clk);
        while (O_busy === 1'b1 && busy_n < 200) begin
            busy_n++;
            @(negedge I_clk);
        end
        check({tag, ".busy_cycles"}, busy_n, exp_busy);
        @(posedge I_clk); #1;
        check({tag, ".valid"}, O_valid, 1);
        check({tag, ".we"}, O_we, 1);
        check({tag, ".regD"}, O_regD, rd);
        want = sb_q.pop_front();
        check({tag, ".result"}, O_result, want);
        I_valid = 0;
    endtask

    task automatic br(input string tag, input logic [2:0] op,
                      input logic [31:0] a, input logic [31:0] b,
                      input logic pred, input logic exp_t,
                      input logic exp_m, input logic [13:0] exp_tgt);
        I_valid = 1; I_isBranch = 1; I_aluop = 4'd14; I_we = 0;
        I_branchop = op; I_dataA = a; I_dataB = b; I_prediction = pred;
        I_PC = 14'h100; I_branchTarget = 14'h200;
        @(negedge I_clk);
        check({tag, ".taken"}, O_branch_taken, exp_t);
        check({tag, ".mispredict"}, O_branch_mispredict, exp_m);
        check({tag, ".target"}, O_branchTarget, exp_tgt);
        @(posedge I_clk); #1;
        I_valid = 0; I_isBranch = 0;
    endtask

    task automatic mem_step(input string tag, input logic [1:0] sel,
                            input logic [31:0] off, input logic st,
                            input logic [31:0] data, input logic [3:0] exp_we,
                            input logic exp_e, input logic exp_mis);
        I_valid = 1; I_aluop = 4'd0; I_selCin = 0; I_we = 0;
        I_dataA = 32'h1000; I_dataB = off; I_memE = 1; I_memWe = st;
        I_selMem = sel; I_storeData = data;
        @(negedge I_clk);
        check({tag, ".addr"}, O_memAddress, 32'h1000 + off);
        check({tag, ".memWe"}, O_memWe, exp_we);
        check({tag, ".memE"}, O_memE, exp_e);
        check({tag, ".misaligned"}, O_misaligned, exp_mis);
        @(posedge I_clk); #1;
        I_valid = 0; I_memE = 0; I_memWe = 0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        clear_inputs();
        I_rst = 1;
        repeat (3) @(posedge I_clk);
        #1;
        check("reset.valid", O_valid, 0);
        check("reset.we", O_we, 0);
        check("reset.result", O_result, 0);
        check("reset.busy", O_busy, 0);
        I_rst = 0;

        run_op("add_wrap", 4'd0, 32'hFFFF_FFFF, 32'h1, 2'd0, 5'd1, 32'h0, 0);
        run_op("add_carry", 4'd0, 32'h0, 32'h0, 2'd1, 5'd2, 32'h1, 0);
        run_op("sub", 4'd1, 32'd5, 32'd3, 2'd3, 5'd3, 32'd2, 0);
        run_op("and", 4'd2, 32'hF0F0_F0F0, 32'hFF00_FF00, 2'd0, 5'd4,
               32'hF000_F000, 0);
        run_op("or", 4'd3, 32'hF0F0_F0F0, 32'hFF00_FF00, 2'd0, 5'd5,
               32'hFFF0_FFF0, 0);
        run_op("xor", 4'd4, 32'hF0F0_F0F0, 32'hFF00_FF00, 2'd0, 5'd6,
               32'h0FF0_0FF0, 0);
        run_op("shl", 4'd5, 32'h1, 32'h23, 2'd0, 5'd7, 32'h8, 0);
        run_op("shr", 4'd6, 32'h8000_0000, 32'd31, 2'd0, 5'd8, 32'h1, 0);
        run_op("sra", 4'd7, 32'h8000_0000, 32'd4, 2'd0, 5'd9,
               32'hF800_0000, 0);
        run_op("sltu", 4'd12, 32'hFFFF_FFFF, 32'h1, 2'd0, 5'd10, 32'h0, 0);
        run_op("slt", 4'd13, 32'hFFFF_FFFF, 32'h1, 2'd0, 5'd11, 32'h1, 0);
        run_op("passb", 4'd15, 32'h1, 32'hCAFE_BABE, 2'd0, 5'd12,
               32'hCAFE_BABE, 0);

        run_op("mul", 4'd8, 32'h10000, 32'h10000, 2'd0, 5'd13, 32'h0, 33);
        run_op("mulhu", 4'd9, 32'h10000, 32'h10000, 2'd0, 5'd14, 32'h1, 33);
        run_op("mul_small", 4'd8, 32'd7, 32'd6, 2'd0, 5'd15, 32'd42, 33);
        run_op("divu", 4'd10, 32'd100, 32'd7, 2'd0, 5'd16, 32'd14, 33);
        run_op("remu", 4'd11, 32'd100, 32'd7, 2'd0, 5'd17, 32'd2, 33);
        run_op("divu0", 4'd10, 32'd5, 32'd0, 2'd0, 5'd18, 32'hFFFF_FFFF, 33);
        run_op("remu0", 4'd11, 32'd5, 32'd0, 2'd0, 5'd19, 32'd5, 33);

        mem_step("st_byte", 2'd2, 32'h3, 1, 32'hAB, 4'b1000, 1, 0);
        check("st_byte.data", O_storeData, 32'hABAB_ABAB);
        mem_step("st_half_mis", 2'd1, 32'h1, 1, 32'h1234, 4'b0000, 0, 1);
        mem_step("st_half", 2'd1, 32'h2, 1, 32'h1234, 4'b1100, 1, 0);
        check("st_half.data", O_storeData, 32'h1234_1234);
        mem_step("ld_full", 2'd0, 32'h4, 0, 32'h0, 4'b0000, 1, 0);
        mem_step("st_full_mis", 2'd3, 32'h6, 1, 32'h0, 4'b0000, 0, 1);
        mem_step("st_full", 2'd3, 32'h8, 1, 32'h0, 4'b1111, 1, 0);

        br("beq_p0", 3'd0, 32'd5, 32'd5, 0, 1, 1, 14'h200);
        br("beq_p1", 3'd0, 32'd5, 32'd5, 1, 1, 0, 14'h100);
        br("blt", 3'd4, 32'hFFFF_FFFF, 32'd1, 1, 1, 0, 14'h100);
        br("bltu", 3'd2, 32'hFFFF_FFFF, 32'd1, 1, 0, 1, 14'h100);

        run_op("c_set", 4'd0, 32'hFFFF_FFFF, 32'h1, 2'd0, 5'd20, 32'h0, 0);
        I_valid = 1; I_aluop = 4'd10; I_dataA = 32'd100; I_dataB = 32'd7;
        I_we = 1; I_regD = 5'd21;
        repeat (4) @(posedge I_clk);
        #1;
        I_flush = 1;
        @(negedge I_clk);
        check("flush.busy_before", O_busy, 1);
        @(posedge I_clk); #1;
        I_flush = 0; I_valid = 0;
        check("flush.valid", O_valid, 0);
        @(negedge I_clk);
        check("flush.busy_after", O_busy, 0);
        @(posedge I_clk); #1;
        check("flush.valid_later", O_valid, 0);
        run_op("flush.next_add", 4'd0, 32'h0, 32'h0, 2'd1, 5'd22, 32'h1, 0);

        run_op("c_set2", 4'd0, 32'hFFFF_FFFF, 32'h1, 2'd0, 5'd23, 32'h0, 0);
        run_op("pre_rst", 4'd14, 32'h0, 32'h5A5A, 2'd0, 5'd24, 32'h5A5A, 0);
        I_valid = 1; I_aluop = 4'd10; I_dataA = 32'd100; I_dataB = 32'd7;
        I_we = 1; I_regD = 5'd25;
        repeat (4) @(posedge I_clk);
        #1;
        I_rst = 1;
        @(negedge I_clk);
        check("rst.busy_before", O_busy, 1);
        @(posedge I_clk); #1;
        I_rst = 0; I_valid = 0;
        check("rst.valid", O_valid, 0);
        check("rst.result", O_result, 0);
        @(negedge I_clk);
        check("rst.busy_after", O_busy, 0);
        @(posedge I_clk); #1;
        run_op("rst.next_add", 4'd0, 32'h0, 32'h0, 2'd1, 5'd26, 32'h0, 0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
